// File: rtl/prism_cfg_pkg.sv
// Shared types and constants for the PRISM configuration sequencer.
package prism_cfg_pkg;

    localparam int PRISM_AW   = 6;
    localparam int PRISM_DW   = 32;
    localparam int CFG_STRIDE = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WRITE,
        S_VERIFY,
        S_RUN_EN,
        S_ERROR
    } cfg_state_e;

endpackage

// File: rtl/prism_cfg_buf.sv
// Config word buffer: push-only register array with a fill count and an
// asynchronous read port addressed by the sequencer.
module prism_cfg_buf
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = PRISM_DW,
    localparam int IW   = $clog2(DEPTH),
    localparam int CW   = IW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          clear,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_reg [DEPTH];
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (push) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Storage carries no reset; words beyond count are never consumed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_reg[count_reg[IW-1:0]] <= push_data;
        end
    end

    assign rd_data = mem_reg[rd_idx];
    assign count   = count_reg;

endmodule

// File: rtl/tqvp_prism_cfg_seq.sv
// PRISM configuration sequencer: halts PRISM, bursts buffered words into its
// config space, optionally reads them back, then releases it to run.
module tqvp_prism_cfg_seq
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AW       = PRISM_AW,
    parameter int DW       = PRISM_DW,
    parameter int VERIFY   = 1,
    parameter int HALT_CYC = 2,
    localparam int IW      = $clog2(DEPTH),
    localparam int CW      = IW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic [AW-1:0] base_addr,
    input  logic          start,
    input  logic          abort,
    input  logic          clear_err,
    output logic [AW-1:0] debug_addr,
    output logic          debug_wr,
    output logic [DW-1:0] debug_wdata,
    input  logic [DW-1:0] debug_rdata,
    output logic          debug_reset,
    output logic          fsm_enable,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_idx,
    output logic [CW-1:0] count
);

    localparam int HW = $clog2(HALT_CYC + 1);

    cfg_state_e    state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [HW-1:0] halt_reg, halt_next;
    logic [AW-1:0] base_reg, base_next;
    logic [AW-1:0] debug_addr_reg;
    logic [DW-1:0] debug_wdata_reg;
    logic          debug_wr_reg, debug_wr_next;
    logic          debug_reset_reg, debug_reset_next;
    logic          fsm_enable_reg, fsm_enable_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          error_reg, error_next;
    logic [IW-1:0] err_idx_reg, err_idx_next;
    logic          wr_ready_reg, wr_ready_next;

    logic          launch, issue, finish, last;
    logic          buf_push, buf_clear;
    logic [CW-1:0] buf_count, count_nx;
    logic [DW-1:0] buf_rd_data;

    prism_cfg_buf #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (wr_data),
        .clear     (buf_clear),
        .rd_idx    (idx_next),
        .rd_data   (buf_rd_data),
        .count     (buf_count)
    );

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        halt_next        = halt_reg;
        base_next        = base_reg;
        debug_wr_next    = 1'b0;
        debug_reset_next = debug_reset_reg;
        fsm_enable_next  = fsm_enable_reg;
        done_next        = 1'b0;
        error_next       = error_reg;
        err_idx_next     = err_idx_reg;
        launch           = 1'b0;
        issue            = 1'b0;
        finish           = 1'b0;
        last             = (CW'(idx_reg) == buf_count - CW'(1));

        if (abort) begin
            state_next       = S_IDLE;
            debug_reset_next = 1'b1;
            fsm_enable_next  = 1'b0;
            error_next       = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && buf_count != '0) launch = 1'b1;
                end
                S_HALT: begin
                    if (halt_reg == '0) begin
                        state_next    = S_WRITE;
                        idx_next      = '0;
                        debug_wr_next = 1'b1;
                        issue         = 1'b1;
                    end else begin
                        halt_next = halt_reg - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (last) begin
                        idx_next = '0;
                        if (VERIFY != 0) begin
                            state_next = S_VERIFY;
                            issue      = 1'b1;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        idx_next      = idx_reg + 1'b1;
                        debug_wr_next = 1'b1;
                        issue         = 1'b1;
                    end
                end
                S_VERIFY: begin
                    // The expected word is still on debug_wdata from the issue step.
                    if (debug_rdata != debug_wdata_reg) begin
                        state_next   = S_ERROR;
                        error_next   = 1'b1;
                        err_idx_next = idx_reg;
                    end else if (last) begin
                        finish = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                        issue    = 1'b1;
                    end
                end
                S_RUN_EN: state_next = S_IDLE;
                S_ERROR: begin
                    if (clear_err) begin
                        state_next = S_IDLE;
                        error_next = 1'b0;
                    end else if (start) begin
                        launch = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        if (launch) begin
            state_next       = S_HALT;
            base_next        = base_addr;
            idx_next         = '0;
            halt_next        = HW'(HALT_CYC - 1);
            error_next       = 1'b0;
            debug_reset_next = 1'b1;
            fsm_enable_next  = 1'b0;
        end
        if (finish) begin
            state_next       = S_RUN_EN;
            debug_reset_next = 1'b0;
            fsm_enable_next  = 1'b1;
            done_next        = 1'b1;
        end

        busy_next     = (state_next != S_IDLE);
        buf_clear     = abort || (state_reg == S_RUN_EN);
        buf_push      = wr_valid && wr_ready_reg;
        count_nx      = buf_clear ? '0 : (buf_push ? buf_count + 1'b1 : buf_count);
        wr_ready_next = (state_next == S_IDLE) && (count_nx < CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            halt_reg        <= '0;
            base_reg        <= '0;
            debug_addr_reg  <= '0;
            debug_wdata_reg <= '0;
            debug_wr_reg    <= 1'b0;
            debug_reset_reg <= 1'b0;
            fsm_enable_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            err_idx_reg     <= '0;
            wr_ready_reg    <= 1'b1;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            halt_reg        <= halt_next;
            base_reg        <= base_next;
            debug_wr_reg    <= debug_wr_next;
            debug_reset_reg <= debug_reset_next;
            fsm_enable_reg  <= fsm_enable_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
            err_idx_reg     <= err_idx_next;
            wr_ready_reg    <= wr_ready_next;
            if (issue) begin
                debug_addr_reg  <= base_next + AW'(CFG_STRIDE * int'(idx_next));
                debug_wdata_reg <= buf_rd_data;
            end
        end
    end

    assign wr_ready    = wr_ready_reg;
    assign debug_addr  = debug_addr_reg;
    assign debug_wr    = debug_wr_reg;
    assign debug_wdata = debug_wdata_reg;
    assign debug_reset = debug_reset_reg;
    assign fsm_enable  = fsm_enable_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;
    assign err_idx     = err_idx_reg;
    assign count       = buf_count;

endmodule

// File: tb/tb_tqvp_prism_cfg_seq.sv
// Bench for the PRISM config sequencer: a write scoreboard on the debug port,
// a memory model answering readbacks, and one task per scenario.
module tb_tqvp_prism_cfg_seq;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [5:0]  base_addr = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        clear_err = 1'b0;
    logic [31:0] debug_rdata;

    logic        wr_ready, debug_wr, debug_reset, fsm_enable, busy, done, error;
    logic [5:0]  debug_addr;
    logic [31:0] debug_wdata;
    logic [2:0]  err_idx;
    logic [3:0]  count;

    logic        nv_wr_ready, nv_debug_wr, nv_debug_reset, nv_fsm_enable, nv_busy, nv_done, nv_error;
    logic [5:0]  nv_debug_addr;
    logic [31:0] nv_debug_wdata;
    logic [2:0]  nv_err_idx;
    logic [3:0]  nv_count;

    int  vectors = 0;
    int  miscompares = 0;
    wr_t exp_q [$];

    logic [31:0] model_mem [16];
    logic        corrupt_en = 1'b0;
    logic [5:0]  corrupt_addr = '0;

    always #5 clk = ~clk;

    tqvp_prism_cfg_seq #(.DEPTH(8), .AW(6), .DW(32), .VERIFY(1), .HALT_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .base_addr(base_addr), .start(start), .abort(abort), .clear_err(clear_err),
        .debug_addr(debug_addr), .debug_wr(debug_wr), .debug_wdata(debug_wdata),
        .debug_rdata(debug_rdata), .debug_reset(debug_reset), .fsm_enable(fsm_enable),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx), .count(count)
    );

    tqvp_prism_cfg_seq #(.DEPTH(8), .AW(6), .DW(32), .VERIFY(0), .HALT_CYC(2)) u_dut_nv (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(nv_wr_ready),
        .base_addr(base_addr), .start(start), .abort(abort), .clear_err(clear_err),
        .debug_addr(nv_debug_addr), .debug_wr(nv_debug_wr), .debug_wdata(nv_debug_wdata),
        .debug_rdata(debug_rdata), .debug_reset(nv_debug_reset), .fsm_enable(nv_fsm_enable),
        .busy(nv_busy), .done(nv_done), .error(nv_error), .err_idx(nv_err_idx), .count(nv_count)
    );

    // PRISM config space model: stores writes, echoes on read, optional bit flip.
    always @(posedge clk) begin
        if (debug_wr) model_mem[debug_addr[5:2]] <= debug_wdata;
    end

    always_comb begin
        debug_rdata = model_mem[debug_addr[5:2]];
        if (corrupt_en && debug_addr == corrupt_addr) debug_rdata = debug_rdata ^ 32'h0000_0100;
    end

    // Scoreboard: every debug write must match the next expected write.
    always @(negedge clk) begin
        if (!rst && debug_wr) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", debug_addr, debug_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({debug_addr, debug_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL wr_data: got addr=%h data=%h, required addr=%h data=%h",
                             debug_addr, debug_wdata, e.addr, e.data);
                end else begin
                    $display("wr addr=%h data=%h ok", debug_addr, debug_wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic start_seq(input logic [5:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle (start cycle = 0) at which done or error rises; 200 on timeout.
    task automatic wait_flag(input bit on_err, output int cyc);
        cyc = 1;
        while (cyc < 200) begin
            @(negedge clk);
            if (on_err ? error : done) return;
            tick();
            cyc++;
        end
    endtask

    task automatic load(input int n, input logic [5:0] b, input logic [31:0] seed, input int n_exp);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = seed + 32'(i) * 32'h0101_0101;
            push_word(w);
            if (i < n_exp) exp_q.push_back('{addr: 6'(int'(b) + 4 * i), data: w});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({wr_ready, busy, done, error, debug_wr, debug_reset, fsm_enable} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 1000000",
                     {wr_ready, busy, done, error, debug_wr, debug_reset, fsm_enable});
        end
        vectors++;
        if ({count, debug_addr, err_idx} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_vals: got count=%0d addr=%h err_idx=%0d, required 0 0 0", count, debug_addr, err_idx);
        end
    endtask

    task automatic test_basic();
        int cyc;
        load(3, 6'h10, 32'hA000_0001, 3);
        @(negedge clk);
        vectors++;
        if (count !== 4'd3) begin miscompares++; $display("FAIL basic_count: got %0d, required 3", count); end
        start_seq(6'h10);
        wait_flag(1'b0, cyc);
        vectors++;
        if (cyc !== 9) begin miscompares++; $display("FAIL basic_latency: got %0d, required 9", cyc); end
        vectors++;
        if ({fsm_enable, debug_reset} !== 2'b10) begin
            miscompares++; $display("FAIL basic_run: got en/rst=%b, required 10", {fsm_enable, debug_reset});
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({done, busy, fsm_enable, count} !== {3'b001, 4'd0}) begin
            miscompares++;
            $display("FAIL basic_after: got done=%b busy=%b en=%b count=%0d, required 0 0 1 0", done, busy, fsm_enable, count);
        end
        $display("basic sequence, done at cycle %0d", cyc);
    endtask

    task automatic test_verify_err();
        int cyc;
        corrupt_en = 1'b1;
        corrupt_addr = 6'h14;
        load(3, 6'h10, 32'h5500_1100, 3);
        start_seq(6'h10);
        wait_flag(1'b1, cyc);
        vectors++;
        if (cyc !== 8) begin miscompares++; $display("FAIL verr_cycle: got %0d, required 8", cyc); end
        vectors++;
        if (err_idx !== 3'd1) begin miscompares++; $display("FAIL verr_idx: got %0d, required 1", err_idx); end
        vectors++;
        if ({fsm_enable, debug_reset, busy, done} !== 4'b0110) begin
            miscompares++; $display("FAIL verr_flags: got %b, required 0110", {fsm_enable, debug_reset, busy, done});
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        corrupt_en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({error, busy, count} !== {2'b00, 4'd3}) begin
            miscompares++; $display("FAIL verr_clear: got err=%b busy=%b count=%0d, required 0 0 3", error, busy, count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        vectors++;
        if ({wr_ready, count} !== {1'b1, 4'd0}) begin
            miscompares++; $display("FAIL verr_abort: got ready=%b count=%0d, required 1 0", wr_ready, count);
        end
        $display("verify error at cycle %0d, err_idx %0d", cyc, err_idx);
    endtask

    task automatic test_overflow();
        int cyc;
        load(8, 6'h20, 32'h0F00_0000, 8);
        @(negedge clk);
        vectors++;
        if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_ready: got %b, required 0", wr_ready); end
        push_word(32'hDEAD_BEEF);
        @(negedge clk);
        vectors++;
        if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d, required 8", count); end
        start_seq(6'h20);
        wait_flag(1'b0, cyc);
        vectors++;
        if (cyc !== 19) begin miscompares++; $display("FAIL ovf_latency: got %0d, required 19", cyc); end
        tick();
        $display("full buffer sequence, done at cycle %0d", cyc);
    endtask

    task automatic test_abort();
        int writes = 0;
        bit saw_done = 1'b0;
        load(3, 6'h08, 32'h7700_0007, 2);
        start_seq(6'h08);
        for (int c = 0; c < 20 && writes < 2; c++) begin
            @(negedge clk);
            if (debug_wr) writes++;
            if (writes < 2) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        vectors++;
        if ({debug_wr, busy, fsm_enable, debug_reset, count} !== {4'b0001, 4'd0}) begin
            miscompares++;
            $display("FAIL abort_state: got wr=%b busy=%b en=%b rst=%b count=%0d, required 0 0 0 1 0",
                     debug_wr, busy, fsm_enable, debug_reset, count);
        end
        for (int c = 0; c < 6; c++) begin
            if (done) saw_done = 1'b1;
            tick();
            @(negedge clk);
        end
        vectors++;
        if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got done, required none"); end
        $display("abort after %0d writes", writes);
    endtask

    task automatic test_wrap();
        int c1 = 0, c2 = 0;
        load(2, 6'h3C, 32'h3C3C_0000, 0);
        exp_q.push_back('{addr: 6'h3C, data: 32'h3C3C_0000});
        exp_q.push_back('{addr: 6'h00, data: 32'h3D3D_0101});
        start_seq(6'h3C);
        for (int c = 1; c < 40 && c1 == 0; c++) begin
            @(negedge clk);
            if (nv_done && c2 == 0) c2 = c;
            if (done) c1 = c;
            tick();
        end
        vectors++;
        if (c1 !== 7) begin miscompares++; $display("FAIL wrap_latency: got %0d, required 7", c1); end
        vectors++;
        if (c2 !== 5) begin miscompares++; $display("FAIL noverify_latency: got %0d, required 5", c2); end
        $display("wrap sequence, done at %0d (verify) and %0d (no verify)", c1, c2);
    endtask

    task automatic test_ignored();
        start_seq(6'h00);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_start: got busy=%b, required 0", busy); end
        load(2, 6'h00, 32'h0000_1234, 2);
        start_seq(6'h00);
        tick();
        tick();
        start_seq(6'h30);
        tick();
        @(negedge clk);
        vectors++;
        if ({busy, debug_wr, debug_addr} !== {2'b10, 6'h00}) begin
            miscompares++; $display("FAIL restart_ignored: got busy=%b wr=%b addr=%h, required 1 0 00", busy, debug_wr, debug_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({wr_ready, busy, done, error, debug_wr, debug_reset, fsm_enable} !== 7'b1000000
            || {count, debug_addr, debug_wdata, err_idx} !== 45'd0) begin
            miscompares++;
            $display("FAIL midrst: got flags=%b count=%0d addr=%h data=%h, required 1000000 0 00 0",
                     {wr_ready, busy, done, error, debug_wr, debug_reset, fsm_enable}, count, debug_addr, debug_wdata);
        end
        tick();
        rst = 1'b0;
        tick();
        $display("async reset mid-verify applied");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_verify_err();
        test_overflow();
        test_abort();
        test_wrap();
        test_ignored();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL wr_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
